fetch_unit: RTL

//   Instruction fetch stage for the bitty core. Holds the program counter and runs a
//   req/gnt/rvalid read handshake to instruction memory. Drives the instruction register
//   (16-bit enabled register) via ir_en_o/ir_d_o, then stalls until execute signals completion.

---
 rtl/fetch_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues req/gnt/rvalid reads to instruction
// memory, loads the IR with a one-cycle enable, then waits for execute to finish.
module fetch_unit #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              ir_en_o,
    output logic [DATA_W-1:0] ir_d_o,
    input  logic              exec_done_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic [15:0]       fetch_cnt_o
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_EXEC = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                ir_en_q, ir_en_d;
    logic [DATA_W-1:0]   ir_d_q, ir_d_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= ADDR_W'(RESET_PC);
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            ir_en_q    <= 1'b0;
            ir_d_q     <= '0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ir_en_q    <= ir_en_d;
            ir_d_q     <= ir_d_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they register cleanly
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        ir_en_d    = 1'b0;
        ir_d_d     = ir_d_q;
        busy_d     = 1'b0;
        cnt_d      = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_REQ;
            end
            S_REQ: begin
                if (mem_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    ir_d_d  = mem_rdata_i;
                    ir_en_d = 1'b1;
                    pc_d    = pc_q + ADDR_W'(1);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done_i) begin
                    if (branch_i) pc_d = branch_addr_i;
                    state_d = run_i ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Address tracks the (possibly branched) PC whenever a request is pending
        mem_req_d = (state_d == S_REQ);
        if (mem_req_d) mem_addr_d = pc_d;
        busy_d = (state_d != S_IDLE);
    end

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign ir_en_o     = ir_en_q;
    assign ir_d_o      = ir_d_q;
    assign pc_o        = pc_q;
    assign busy_o      = busy_q;
    assign fetch_cnt_o = cnt_q;

endmodule
